// File: rtl/ls_port_arbiter_pkg.sv
// ls_port_arbiter_pkg: shared request payload and arbiter state types for the LSU port arbiter.
package ls_port_arbiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        load;
        logic        store;
    } ls_port_req_t;
    typedef enum logic {OWN, DRAIN} ls_arb_state_t;
endpackage

// File: rtl/ls_port_arbiter_if.sv
// ls_port_arbiter_if: requester-side bundle of the LSU port arbiter (requests, locks, load returns).
interface ls_port_arbiter_if #(parameter int NUM_PORTS = 2);
    import ls_port_arbiter_pkg::*;
    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] req_ready;
    ls_port_req_t         req [NUM_PORTS];
    logic [NUM_PORTS-1:0] lock;
    logic [NUM_PORTS-1:0] resp_valid;
    logic [31:0]          resp_data;
    modport master (output req_valid, req, lock, input req_ready, resp_valid, resp_data);
    modport slave (input req_valid, req, lock, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/ls_port_arbiter_rr_select.sv
// ls_port_arbiter_rr_select: combinational round-robin pick of the first set bit at or after start.
module ls_port_arbiter_rr_select #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] start,
    output logic [W-1:0] grant,
    output logic         any_valid
);
    logic [W-1:0] idx;
    // Walk offsets from farthest to nearest so the closest set bit wins.
    always_comb begin
        grant = '0;
        any_valid = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(start) + i) % N);
            if (valid[idx]) begin
                grant = idx;
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ls_port_arbiter.sv
// ls_port_arbiter: multiplexes NUM_PORTS requesters onto the LSU; accelerators take ownership by lock after a drain.
module ls_port_arbiter import ls_port_arbiter_pkg::*; #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PORT_W = $clog2(NUM_PORTS)
) (
    input  logic               clk,
    input  logic               rst,
    ls_port_arbiter_if.slave   ports,
    output logic               lsu_valid,
    input  logic               lsu_ready,
    output ls_port_req_t       lsu_req,
    output logic               lsu_from_cpu,
    input  logic               lsu_empty,
    input  logic               load_complete,
    input  logic [31:0]        load_data,
    output logic [PORT_W-1:0]  owner,
    output logic               err_spurious
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    ls_arb_state_t state, state_n;
    logic [PORT_W-1:0] owner_q, owner_n, rr_ptr, rr_n, grant;
    logic [CNT_W-1:0] outstanding, outstanding_n;
    logic [NUM_PORTS-1:0] acc_lock, ready_c;
    logic err_q, any_lock, own, full, accept_load, switch_req, drained;
    ls_port_req_t cur;
    assign acc_lock = ports.lock & ~NUM_PORTS'(1);
    assign cur = ports.req[owner_q];
    assign own = (state == OWN) & ~rst;
    assign full = outstanding == CNT_W'(MAX_OUTSTANDING);
    // A load that would exceed the in-flight limit is withheld from the LSU as well as from the requester.
    assign lsu_valid = own & ports.req_valid[owner_q] & ~(cur.load & full);
    assign lsu_req = cur;
    assign accept_load = lsu_valid & lsu_ready & cur.load;
    assign lsu_from_cpu = rst | (owner_q == '0);
    assign owner = rst ? '0 : owner_q;
    assign err_spurious = err_q;
    assign ports.resp_valid = (~rst & load_complete) ? NUM_PORTS'(1) << owner_q : '0;
    assign ports.resp_data = load_data;
    assign ports.req_ready = ready_c;
    assign switch_req = (owner_q == '0) ? |acc_lock : ~ports.lock[owner_q];
    assign drained = lsu_empty & (outstanding == '0);
    always_comb begin
        ready_c = '0;
        if (own) ready_c[owner_q] = lsu_ready & ~(cur.load & full);
    end
    ls_port_arbiter_rr_select #(.N(NUM_PORTS), .W(PORT_W)) u_rr (
        .valid     (acc_lock),
        .start     (rr_ptr),
        .grant     (grant),
        .any_valid (any_lock)
    );
    always_comb begin
        state_n = state;
        owner_n = owner_q;
        rr_n = rr_ptr;
        if (state == OWN) state_n = switch_req ? DRAIN : OWN;
        else if (drained) begin
            state_n = OWN;
            owner_n = any_lock ? grant : '0;
            rr_n = !any_lock ? rr_ptr : (grant == PORT_W'(NUM_PORTS - 1)) ? PORT_W'(1) : grant + PORT_W'(1);
        end
    end
    assign outstanding_n = (accept_load & ~load_complete) ? outstanding + CNT_W'(1) :
                           (~accept_load & load_complete & outstanding != '0) ? outstanding - CNT_W'(1) :
                           outstanding;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OWN;
            owner_q <= '0;
            rr_ptr <= PORT_W'(1);
            outstanding <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            owner_q <= owner_n;
            rr_ptr <= rr_n;
            outstanding <= outstanding_n;
            err_q <= err_q | (load_complete & outstanding == '0);
        end
    end
endmodule

// File: tb/tb_ls_port_arbiter.sv
// tb_ls_port_arbiter: directed bench with a load-return scoreboard for ls_port_arbiter (3 ports, 2 in flight).
module tb_ls_port_arbiter;
    import ls_port_arbiter_pkg::*;
    localparam int NP = 3;
    typedef struct {
        logic [NP-1:0] port;
        logic [31:0]   data;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lsu_valid, lsu_ready, lsu_from_cpu, lsu_empty, load_complete, err_spurious;
    ls_port_req_t lsu_req;
    logic [31:0] load_data;
    logic [1:0] owner;
    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    exp_t e;
    ls_port_arbiter_if #(.NUM_PORTS(NP)) pif();
    ls_port_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ports         (pif),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_req       (lsu_req),
        .lsu_from_cpu  (lsu_from_cpu),
        .lsu_empty     (lsu_empty),
        .load_complete (load_complete),
        .load_data     (load_data),
        .owner         (owner),
        .err_spurious  (err_spurious)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction
    task automatic drive(input int p, input logic v, input logic [31:0] a);
        pif.req_valid[p] = v;
        pif.req[p] = '{addr: a, data: 32'h0, fn3: 3'b010, load: 1'b1, store: 1'b0};
    endtask
    task automatic expect_load(input int p, input logic [31:0] d);
        exp_q.push_back('{port: NP'(1 << p), data: d});
    endtask
    task automatic complete(input logic [31:0] d);
        load_complete = 1'b1;
        load_data = d;
        tick();
        load_complete = 1'b0;
    endtask
    // Every load return is matched against the oldest expected (port, data) pair.
    always @(negedge clk) begin
        if (!rst && load_complete) begin
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_resp_valid", 64'(pif.resp_valid), 64'(e.port));
                chk("sb_resp_data", 64'(pif.resp_data), 64'(e.data));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        pif.req_valid = '0;
        pif.lock = '0;
        for (int i = 0; i < NP; i++) drive(i, 1'b0, 32'h0);
        lsu_ready = 1'b1;
        lsu_empty = 1'b1;
        load_complete = 1'b0;
        load_data = '0;
        tick();
        drive(0, 1'b1, 32'h100);
        load_complete = 1'b1;
        #1;
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_from_cpu", 64'(lsu_from_cpu), 64'd1);
        chk("rst_req_ready", 64'(pif.req_ready), 64'd0);
        chk("rst_lsu_valid", 64'(lsu_valid), 64'd0);
        chk("rst_resp_valid", 64'(pif.resp_valid), 64'd0);
        load_complete = 1'b0;
        pif.req_valid = '0;
        tick();
        rst = 1'b0;
        #1;
        chk("idle_err", 64'(err_spurious), 64'd0);
        chk("idle_owner", 64'(owner), 64'd0);
        // CPU loads against a limit of two in flight
        drive(0, 1'b1, 32'h1000);
        #1;
        chk("t1_ready_a", 64'(pif.req_ready), 64'b001);
        chk("t1_lsu_addr", 64'(lsu_req.addr), 64'h1000);
        expect_load(0, mem(32'h1000));
        tick();
        drive(0, 1'b1, 32'h1004);
        #1;
        chk("t1_ready_b", 64'(pif.req_ready), 64'b001);
        expect_load(0, mem(32'h1004));
        tick();
        drive(0, 1'b1, 32'h1008);
        #1;
        chk("t1_full_ready", 64'(pif.req_ready), 64'd0);
        chk("t1_full_valid", 64'(lsu_valid), 64'd0);
        tick();
        tick();
        tick();
        load_complete = 1'b1;
        load_data = mem(32'h1000);
        #1;
        chk("t1_full_on_complete", 64'(pif.req_ready), 64'd0);
        tick();
        load_complete = 1'b0;
        #1;
        chk("t1_third_ready", 64'(pif.req_ready), 64'b001);
        expect_load(0, mem(32'h1008));
        tick();
        pif.req_valid[0] = 1'b0;
        complete(mem(32'h1004));
        complete(mem(32'h1008));
        // lock[1] with a CPU load still in flight
        drive(0, 1'b1, 32'h2000);
        expect_load(0, mem(32'h2000));
        tick();
        pif.req_valid[0] = 1'b0;
        lsu_empty = 1'b0;
        pif.lock = 3'b010;
        tick();
        pif.req_valid = 3'b011;
        #1;
        chk("t2_drain_ready", 64'(pif.req_ready), 64'd0);
        chk("t2_drain_valid", 64'(lsu_valid), 64'd0);
        chk("t2_drain_owner", 64'(owner), 64'd0);
        pif.req_valid = '0;
        lsu_empty = 1'b1;
        complete(mem(32'h2000));
        #1;
        chk("t2_wait_owner", 64'(owner), 64'd0);
        tick();
        chk("t2_owner", 64'(owner), 64'd1);
        chk("t2_from_cpu", 64'(lsu_from_cpu), 64'd0);
        drive(1, 1'b1, 32'h3000);
        #1;
        chk("t2_p1_ready", 64'(pif.req_ready), 64'b010);
        chk("t2_p1_addr", 64'(lsu_req.addr), 64'h3000);
        expect_load(1, mem(32'h3000));
        tick();
        pif.req_valid[1] = 1'b0;
        complete(mem(32'h3000));
        pif.lock = '0;
        tick();
        tick();
        chk("t2_back_cpu", 64'(owner), 64'd0);
        // round-robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pif.lock = 3'b110;
        tick();
        tick();
        chk("t3_owner1", 64'(owner), 64'd1);
        pif.lock = 3'b100;
        tick();
        tick();
        chk("t3_owner2", 64'(owner), 64'd2);
        pif.lock = '0;
        tick();
        tick();
        chk("t3_owner0", 64'(owner), 64'd0);
        // accelerator 2 keeps ownership until its lock drops
        pif.lock = 3'b100;
        tick();
        tick();
        chk("t4_owner2", 64'(owner), 64'd2);
        pif.lock = 3'b110;
        tick();
        tick();
        chk("t4_no_preempt", 64'(owner), 64'd2);
        pif.lock = 3'b010;
        tick();
        chk("t4_drain_owner", 64'(owner), 64'd2);
        tick();
        chk("t4_owner1", 64'(owner), 64'd1);
        drive(1, 1'b1, 32'h4000);
        expect_load(1, 32'hDEADBEEF);
        tick();
        pif.req_valid[1] = 1'b0;
        load_complete = 1'b1;
        load_data = 32'hDEADBEEF;
        #1;
        chk("t4_resp_valid", 64'(pif.resp_valid), 64'b010);
        tick();
        load_complete = 1'b0;
        // outstanding counter: simultaneous accept/complete, then a spurious return
        drive(1, 1'b1, 32'h5000);
        expect_load(1, mem(32'h5000));
        tick();
        drive(1, 1'b1, 32'h5004);
        load_complete = 1'b1;
        load_data = mem(32'h5000);
        #1;
        chk("t5_sim_ready", 64'(pif.req_ready), 64'b010);
        expect_load(1, mem(32'h5004));
        tick();
        load_complete = 1'b0;
        pif.req_valid[1] = 1'b0;
        complete(mem(32'h5004));
        #1;
        chk("t5_no_err", 64'(err_spurious), 64'd0);
        expect_load(1, 32'h1234);
        complete(32'h1234);
        #1;
        chk("t5_err_set", 64'(err_spurious), 64'd1);
        tick();
        tick();
        chk("t5_err_sticky", 64'(err_spurious), 64'd1);
        // reset while draining with two loads in flight
        drive(1, 1'b1, 32'h6000);
        #1;
        chk("t6_ready_a", 64'(pif.req_ready), 64'b010);
        tick();
        drive(1, 1'b1, 32'h6004);
        #1;
        chk("t6_ready_b", 64'(pif.req_ready), 64'b010);
        tick();
        pif.req_valid[1] = 1'b0;
        lsu_empty = 1'b0;
        pif.lock = '0;
        tick();
        chk("t6_drain_owner", 64'(owner), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_owner", 64'(owner), 64'd0);
        chk("t6_rst_from_cpu", 64'(lsu_from_cpu), 64'd1);
        tick();
        rst = 1'b0;
        lsu_empty = 1'b1;
        #1;
        chk("t6_err_clear", 64'(err_spurious), 64'd0);
        chk("t6_owner", 64'(owner), 64'd0);
        drive(0, 1'b1, 32'h7000);
        #1;
        chk("t6_ready_0", 64'(pif.req_ready), 64'b001);
        expect_load(0, mem(32'h7000));
        tick();
        drive(0, 1'b1, 32'h7004);
        #1;
        chk("t6_ready_1", 64'(pif.req_ready), 64'b001);
        expect_load(0, mem(32'h7004));
        tick();
        drive(0, 1'b1, 32'h7008);
        #1;
        chk("t6_full", 64'(pif.req_ready), 64'd0);
        pif.req_valid[0] = 1'b0;
        complete(mem(32'h7000));
        complete(mem(32'h7004));
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ls_port_arbiter.md
# ls_port_arbiter

Parametrised arbiter that multiplexes NUM_PORTS requesters onto the single load/store unit request path. Port 0 is the CPU issue path and the default owner; ports 1..NUM_PORTS-1 are accelerator ports that claim exclusive LSU ownership via a lock. Ownership changes only after the LSU queue is empty and every outstanding load has returned. Load data is routed back to the owning port. This block generalises the two-mode CPU/RCA switch to N channels, with round-robin fairness and bounded outstanding loads.

## Interface
- NUM_PORTS, 2: requester count (≥2); port 0 = CPU.
- MAX_OUTSTANDING, 4: max loads in flight (≥1).
- PORT_W, $clog2(NUM_PORTS): owner index width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accepted this cycle.
- req  in  NUM_PORTS × ls_port_req_t  per-port {addr[31:0], data[31:0], fn3[2:0], load, store}.
- lock  in  NUM_PORTS  ownership claim; bit 0 ignored.
- lsu_valid  out  1  request to LSU.
- lsu_ready  in  1  LSU queue can accept.
- lsu_req  out  ls_port_req_t  muxed payload of owner.
- lsu_from_cpu  out  1  owner==0; LSU gates store_complete/wb.done with it.
- lsu_empty  in  1  LSU queue empty.
- load_complete  in  1  LSU load data valid.
- load_data  in  32  LSU load result.
- resp_valid  out  NUM_PORTS  one-hot load return to owner.
- resp_data  out  32  = load_data.
- owner  out  PORT_W  current owner.
- err_spurious  out  1  sticky: load_complete seen with zero outstanding.

## Operation
- States: OWN, DRAIN. Reset: OWN, owner=0, outstanding=0, rr_ptr=1, err_spurious=0.
- Outputs during rst: req_ready=0, lsu_valid=0, resp_valid=0, owner=0, lsu_from_cpu=1.
- OWN: lsu_valid = req_valid[owner]; lsu_req = req[owner]; req_ready[owner] = lsu_ready & ~(req.load & outstanding==MAX_OUTSTANDING). Non-owners: req_ready=0.
- Switch condition in OWN (registered move to DRAIN):
  - owner==0 and any lock[k≥1] set.
  - owner≠0 and lock[owner] clear.
- DRAIN: lsu_valid=0 and all req_ready=0. Exit when lsu_empty & outstanding==0.
- On DRAIN exit, new owner is picked by round-robin. Search the set lock bits from rr_ptr upward, wrapping over 1..NUM_PORTS-1. If none are set, the new owner is 0.
- On exit to an accelerator k, rr_ptr ← k+1, wrapping to 1. The new owner is registered and the state returns to OWN.
- If a lock drops during DRAIN, arbitration uses lock values at the exit cycle; an empty set yields owner 0.
- Accelerators hold ownership for as long as lock stays asserted. There is no preemption.
- Outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on an accepted load; −1 on load_complete; both at once = unchanged.
  - load_complete at 0: counter holds at 0 and err_spurious sets.
- Responses: resp_valid[owner] = load_complete, combinational; resp_data = load_data. Loads never straddle an owner change.
- Stores do not count as outstanding; drain relies on lsu_empty.

## Timing
- Request path is combinational: accept in cycle t ⇔ lsu_valid & lsu_ready in t.
- Load response is zero-latency pass-through of load_complete.
- Lock change sampled at edge t gives DRAIN in t+1. If already drained in t+1, the new owner is OWN in t+2 and can be accepted in t+2. Minimum switch bubble: 1 cycle.
- Reset mid-operation: all state clears at the next edge. The LSU is reset in the same cycle, so in-flight loads are discarded.

## Structure
- Shared package (taiga_types): ls_port_req_t struct; ls_arb_state_t enum {OWN, DRAIN}.
- Sub-module ls_rr_select: combinational round-robin pick over a request vector from a start pointer. Outputs grant index and any_valid. Reused for other multi-master arbiters.
- Estimated 150–250 RTL lines.

## Test plan
- CPU only, NUM_PORTS=3, MAX_OUTSTANDING=2: three back-to-back loads with load_complete delayed 5 cycles → third load has req_ready=0 until the first completes; resp_valid=3'b001.
- lock[1] raised while one CPU load is outstanding → DRAIN until load_complete and lsu_empty; owner=1 one cycle later; lsu_from_cpu=0.
- lock[1] and lock[2] both raised at reset-idle → owner=1. Drop lock[1] → owner=2. Drop lock[2] → owner=0 (rr_ptr wraps to 1).
- Accelerator 2 owns; lock[2] drops while lock[1] is held → DRAIN, then owner=1. A load from port 1 returns 0xDEADBEEF on resp_valid=3'b010.
- Simultaneous load accept and load_complete with outstanding=1 → counter stays at 1. load_complete with outstanding=0 → err_spurious=1 and sticky.
- rst asserted while in DRAIN with outstanding=2 → next cycle state OWN, owner=0, outstanding=0, err_spurious=0.
